// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: ALU ops, PC / ALU-B selects,
// register address width and the immediate sign-extension helper.
package mips_pkg;

  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_e;

  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 2-read / 1-write register file. Register 0 is hardwired to zero; reads are
// combinational, so a same-cycle write is seen only on the following cycle.
module reg_file
  import mips_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [31:0]       rdata_a,
  output logic [31:0]       rdata_b
);

  logic [31:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR, data register, A/B, ALUOut, register file
// and inline ALU, steered entirely by the control unit's strobes.
module multicycle_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_to_reg,
  input  logic        reg_dest,
  input  logic        i_or_d,
  input  logic        alu_src_a,
  input  logic [1:0]  alu_src_b,
  input  logic        ir_write,
  input  logic        pc_write,
  input  logic        branch,
  input  logic        reg_write,
  input  logic [1:0]  pc_src,
  input  logic [2:0]  alu_control,
  input  logic [31:0] mem_rdata,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        zero_o
);

  logic [31:0] pc, ir, mdr, a_q, b_q, alu_out;
  logic [31:0] rd_a, rd_b, src_a, src_b, alu_res, imm, pc_next;
  logic [REG_AW-1:0] waddr;
  logic [31:0] wdata;
  logic        pc_en;

  assign imm    = sign_ext(ir[15:0]);
  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  // Write port decodes from the current IR, so a same-cycle IR load does not
  // affect the destination of an in-flight writeback.
  assign waddr = reg_dest ? ir[15:11] : ir[20:16];
  assign wdata = mem_to_reg ? mdr : alu_out;

  reg_file #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_write),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (ir[25:21]),
    .raddr_b (ir[20:16]),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  assign src_a = alu_src_a ? a_q : pc;

  always_comb begin
    src_b = b_q;
    case (alu_src_b)
      SRCB_REG:     src_b = b_q;
      SRCB_FOUR:    src_b = 32'd4;
      SRCB_IMM:     src_b = imm;
      SRCB_IMM_SH2: src_b = {imm[29:0], 2'b00};
      default:      src_b = b_q;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_control)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_SLT: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_res = '0;
    endcase
  end

  assign zero_o = (alu_res == '0);
  assign pc_en  = pc_write | (branch & zero_o);

  always_comb begin
    pc_next = pc;
    case (pc_src)
      PC_ALU:    pc_next = alu_res;
      PC_ALUOUT: pc_next = alu_out;
      PC_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      PC_HOLD:   pc_next = pc;
      default:   pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
    end else begin
      if (pc_en)    pc <= pc_next;
      if (ir_write) ir <= mem_rdata;
      mdr     <= mem_rdata;
      a_q     <= rd_a;
      b_q     <= rd_b;
      alu_out <= alu_res;
    end
  end

  assign mem_addr  = i_or_d ? alu_out : pc;
  assign mem_wdata = b_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed MIPS sequences plus randomized control traffic, all checked against
// an architectural-level model of the datapath state.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, pc_write;
  logic        branch, reg_write;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic [31:0] mem_rdata;
  logic [5:0]  opcode, funct;
  logic [31:0] mem_addr, mem_wdata;
  logic        zero_o;

  int tests = 0;
  int fails = 0;

  multicycle_datapath dut (
    .clk(clk), .reset(reset), .mem_to_reg(mem_to_reg), .reg_dest(reg_dest),
    .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .reg_write(reg_write), .pc_src(pc_src), .alu_control(alu_control),
    .mem_rdata(mem_rdata), .opcode(opcode), .funct(funct),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  // Architectural view of the machine state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_ao;
  logic [31:0] m_rf [32];

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'b010:  return x + y;
      3'b110:  return x + (~y + 32'd1);
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, x < y};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    logic [31:0] x, y, se;
    se = {{16{m_ir[15]}}, m_ir[15:0]};
    x  = alu_src_a ? m_a : m_pc;
    case (alu_src_b)
      2'd0: y = m_b;
      2'd1: y = 32'd4;
      2'd2: y = se;
      default: y = se * 4;
    endcase
    return m_alu(alu_control, x, y);
  endfunction

  task automatic model_clock();
    logic [31:0] res, na, nb, wd;
    logic [4:0]  wa;
    if (reset) begin
      m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_ao = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      res = m_result();
      na  = m_rf[m_ir[25:21]];
      nb  = m_rf[m_ir[20:16]];
      wa  = reg_dest ? m_ir[15:11] : m_ir[20:16];
      wd  = mem_to_reg ? m_mdr : m_ao;
      if (pc_write || (branch && res == 0)) begin
        case (pc_src)
          2'd0: m_pc = res;
          2'd1: m_pc = m_ao;
          2'd2: m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
          default: ;
        endcase
      end
      if (reg_write && wa != 0) m_rf[wa] = wd;
      if (ir_write) m_ir = mem_rdata;
      m_mdr = mem_rdata;
      m_a   = na;
      m_b   = nb;
      m_ao  = res;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model mid-cycle, then advance both.
  task automatic cyc(input bit chk = 1'b1);
    @(negedge clk);
    if (chk) begin
      check("mem_addr",  mem_addr,  i_or_d ? m_ao : m_pc);
      check("mem_wdata", mem_wdata, m_b);
      check("opcode",    {26'd0, opcode}, {26'd0, m_ir[31:26]});
      check("funct",     {26'd0, funct},  {26'd0, m_ir[5:0]});
      check("zero_o",    {31'd0, zero_o}, {31'd0, m_result() == 0});
    end
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    reset = 0; mem_to_reg = 0; reg_dest = 0; i_or_d = 0; alu_src_a = 0;
    alu_src_b = 0; ir_write = 0; pc_write = 0; branch = 0; reg_write = 0;
    pc_src = 0; alu_control = 3'b010; mem_rdata = 0;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    idle(); mem_rdata = instr; ir_write = 1; cyc(); idle();
  endtask

  // IR carries rs=rt=idx so the writeback targets idx and both latches read it
  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    load_ir({6'h23, idx, idx, 16'h0});
    mem_rdata = val; cyc();
    mem_rdata = val; mem_to_reg = 1; reg_write = 1; cyc(); idle();
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle(); mem_rdata = instr; ir_write = 1; alu_src_b = 2'b01;
    pc_write = 1; cyc(); idle();
  endtask

  task automatic peek_pc(input string tag, input logic [31:0] exp);
    idle(); #1; check(tag, mem_addr, exp);
  endtask

  task automatic peek_aluout(input string tag, input logic [31:0] exp);
    idle(); i_or_d = 1; #1; check(tag, mem_addr, exp); idle();
  endtask

  logic [31:0] p0;

  initial begin
    idle();
    reset = 1; cyc(1'b0); cyc(1'b0);
    idle(); #1;
    check("rst_pc", mem_addr, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'h0);
    check("rst_funct", {26'd0, funct}, 32'h0);
    check("rst_b", mem_wdata, 32'h0);

    // fetch lw $8, 4($0)
    fetch(32'h8C08_0004);
    check("fetch_opcode", {26'd0, opcode}, 32'h23);
    peek_pc("fetch_pc", 32'h4);

    // lw: decode, memaddr, memread, writeback
    alu_src_b = 2'b11; cyc();
    idle(); alu_src_a = 1; alu_src_b = 2'b10; cyc();
    idle(); i_or_d = 1; mem_rdata = 32'hDEAD_BEEF; #1;
    check("lw_memaddr", mem_addr, 32'h4);
    cyc();
    idle(); mem_to_reg = 1; reg_write = 1; cyc();
    idle(); cyc();
    check("lw_r8_via_b", mem_wdata, 32'hDEAD_BEEF);

    // beq taken / not taken
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd5);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) write_reg(5'd2, 32'd6);
      p0 = m_pc;
      fetch({6'h04, 5'd1, 5'd2, 16'd3});
      alu_src_b = 2'b11; cyc();
      idle(); alu_src_a = 1; alu_control = 3'b110; branch = 1; pc_src = 2'b01; #1;
      check("beq_zero", {31'd0, zero_o}, (k == 0) ? 32'd1 : 32'd0);
      cyc();
      peek_pc(k == 0 ? "beq_taken_pc" : "beq_not_taken_pc", (k == 0) ? p0 + 32'd16 : p0 + 32'd4);
    end

    // jump from PC=A000_0010
    write_reg(5'd9, 32'hA000_0010);
    load_ir({6'h00, 5'd9, 5'd0, 16'h0});
    cyc();
    alu_src_a = 1; alu_control = 3'b001; pc_write = 1; cyc();
    peek_pc("jump_setup_pc", 32'hA000_0010);
    load_ir(32'h0800_0040);
    pc_src = 2'b10; pc_write = 1; cyc();
    peek_pc("jump_pc", 32'hA000_0100);

    // r0 protection and same-cycle read-after-write
    write_reg(5'd0, 32'h1234);
    cyc();
    check("r0_reads_zero", mem_wdata, 32'h0);
    write_reg(5'd3, 32'd7);
    check("raw_old", mem_wdata, 32'h0);
    cyc();
    check("raw_new", mem_wdata, 32'd7);

    // ALU corners with A=r4, B=r5
    write_reg(5'd4, 32'hFFFF_FFFF);
    write_reg(5'd5, 32'd1);
    load_ir({6'h00, 5'd4, 5'd5, 16'h0});
    cyc();
    alu_src_a = 1; alu_control = 3'b111; cyc();
    peek_aluout("slt_neg", 32'd1);
    write_reg(5'd4, 32'h7FFF_FFFF);
    load_ir({6'h00, 5'd4, 5'd5, 16'h0});
    cyc();
    alu_src_a = 1; alu_control = 3'b010; cyc();
    peek_aluout("add_wrap", 32'h8000_0000);
    alu_src_a = 1; alu_control = 3'b011; #1;
    check("undef_zero", {31'd0, zero_o}, 32'd1);
    cyc();
    peek_aluout("undef_res", 32'h0);

    // randomized control traffic
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      mem_to_reg  = 1'($urandom);
      reg_dest    = 1'($urandom);
      i_or_d      = 1'($urandom);
      alu_src_a   = 1'($urandom);
      alu_src_b   = 2'($urandom);
      ir_write    = ($urandom_range(0, 3) == 0);
      pc_write    = ($urandom_range(0, 3) == 0);
      branch      = 1'($urandom);
      reg_write   = 1'($urandom);
      pc_src      = 2'($urandom);
      alu_control = 3'($urandom);
      mem_rdata   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cyc();
    end
    idle(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
